// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter fed from a small circular FIFO.
// Frame: START, DATA (LSB first), optional PARITY, STOP, GAP.
// Optional parity bit is built in when UART_TX_PARITY_EN is defined.
//
// state  | meaning
// IDLE   | line high, waiting for a queued word
// START  | start bit, line low
// DATA   | data bits, LSB first
// PARITY | parity bit (UART_TX_PARITY_EN builds only)
// STOP   | stop bit(s), line high
// GAP    | inter-frame idle bit periods, line high
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 1,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int IDLE_BITS    = 1,
    parameter int FIFO_DEPTH   = 4,
    parameter int PARITY_ODD   = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_BITS-1:0]          tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx_pin,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int LVL_W    = PTR_W + 1;
    localparam int BAUD_W   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int MAX_BITS = (DATA_BITS > STOP_BITS)
                              ? ((DATA_BITS > IDLE_BITS) ? DATA_BITS : IDLE_BITS)
                              : ((STOP_BITS > IDLE_BITS) ? STOP_BITS : IDLE_BITS);
    localparam int BIT_W    = $clog2(MAX_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic [BIT_W-1:0]  GAP_LAST  = BIT_W'((IDLE_BITS > 0) ? IDLE_BITS - 1 : 0);
    localparam logic [LVL_W-1:0]  LVL_FULL  = LVL_W'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;

    // Elaboration-time parameter sanity checks
    if (CLKS_PER_BIT < 1) begin : g_chk_clks
        $error("uart_tx_fifo: CLKS_PER_BIT must be >= 1");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_chk_data
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_chk_stop
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (IDLE_BITS < 0) begin : g_chk_idle
        $error("uart_tx_fifo: IDLE_BITS must be >= 0");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
    if (PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_chk_par
        $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
    end

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]     level_q, level_d;

    logic [2:0]           state_q, state_d;
    logic [BAUD_W-1:0]    baud_q, baud_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_pin_q, tx_pin_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    logic full, empty, push, pop, bit_end, frame_done;

    assign full       = (level_q == LVL_FULL);
    assign empty      = (level_q == '0);
    // A pop in the same cycle never frees room for a push: ready looks at full only.
    assign tx_ready   = ~reset & ~full;
    assign push       = tx_valid & tx_ready;
    assign tx_pin     = tx_pin_q;
    assign busy       = (state_q != S_IDLE) | ~empty;
    assign fifo_level = level_q;

    // FIFO storage write; contents need no reset since reads only happen when non-empty
    always_comb begin
        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = tx_data;
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    // Frame sequencer: baud counter, bit counter, shift register and next line level
    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        pop        = 1'b0;
        frame_done = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif
        bit_end = (baud_q == BAUD_LAST);
        if (state_q != S_IDLE) baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);

        case (state_q)
            S_IDLE:  pop = ~empty;
            S_START: if (bit_end) state_d = S_DATA;
            S_DATA: begin
                if (bit_end) begin
                    if (bit_q == DATA_LAST) begin
                        bit_d = '0;
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d   = bit_q + BIT_W'(1);
                        shift_d = shift_q >> 1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (bit_end) state_d = S_STOP;
`endif
            S_STOP: begin
                if (bit_end) begin
                    if (bit_q == STOP_LAST) begin
                        bit_d = '0;
                        if (IDLE_BITS > 0) state_d = S_GAP;
                        else               frame_done = 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_GAP: begin
                if (bit_end) begin
                    if (bit_q == GAP_LAST) begin
                        bit_d      = '0;
                        frame_done = 1'b1;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // End of frame chains straight into the next START when a word is waiting.
        if (frame_done) begin
            state_d = S_IDLE;
            pop     = ~empty;
        end

        if (pop) begin
            state_d = S_START;
            baud_d  = '0;
            bit_d   = '0;
            shift_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
            par_d   = (^mem_q[rd_ptr_q]) ^ (PARITY_ODD != 0);
`endif
        end

        // Line level is registered, so it follows the state being entered.
        case (state_d)
            S_START:  tx_pin_d = 1'b0;
            S_DATA:   tx_pin_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_pin_d = par_d;
`endif
            default:  tx_pin_d = 1'b1;
        endcase
    end

    // FIFO storage register
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control state registers with synchronous reset; reset abandons any frame in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            state_q  <= S_IDLE;
            baud_q   <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_pin_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_pin_q <= tx_pin_d;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Testbench for uart_tx_fifo: table-driven frames, hand sequences for FIFO-full,
// pointer wrap, mid-frame reset and back-to-back 2-stop frames, plus randomized
// traffic checked every cycle against a frame-schedule reference model.
module tb_uart_tx_fifo;
`ifdef UART_TX_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int CLK   = 4;
    localparam int DEPTH = 4;
    localparam int NB    = 11 + P;
    localparam int FLEN  = NB * CLK;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready_a, tx_pin_a, busy_a;
    logic [2:0] level_a;
    logic       tx_ready_c, tx_pin_c, busy_c;
    logic [2:0] level_c;
    logic [7:0] b_data;
    logic       b_valid;
    logic       tx_ready_b, tx_pin_b, busy_b;
    logic [2:0] level_b;

    always #5 clk = ~clk;

    uart_tx_fifo #(.CLKS_PER_BIT(CLK), .DATA_BITS(8), .STOP_BITS(1), .IDLE_BITS(1),
                   .FIFO_DEPTH(DEPTH), .PARITY_ODD(0)) dut_a (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready_a), .tx_pin(tx_pin_a), .busy(busy_a), .fifo_level(level_a));

    uart_tx_fifo #(.CLKS_PER_BIT(CLK), .DATA_BITS(8), .STOP_BITS(1), .IDLE_BITS(1),
                   .FIFO_DEPTH(DEPTH), .PARITY_ODD(1)) dut_c (
        .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready_c), .tx_pin(tx_pin_c), .busy(busy_c), .fifo_level(level_c));

    uart_tx_fifo #(.CLKS_PER_BIT(1), .DATA_BITS(8), .STOP_BITS(2), .IDLE_BITS(0),
                   .FIFO_DEPTH(4), .PARITY_ODD(0)) dut_b (
        .clk(clk), .reset(reset), .tx_data(b_data), .tx_valid(b_valid),
        .tx_ready(tx_ready_b), .tx_pin(tx_pin_b), .busy(busy_b), .fifo_level(level_b));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bit idx of a frame carrying word w: start, data LSB first, parity, then high bits.
    function automatic logic frame_bit(input logic [7:0] w, input int idx, input bit odd);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return w[idx-1];
        if (P == 1 && idx == 9) return (^w) ^ odd;
        return 1'b1;
    endfunction

    // Expected frame from an 11-bit no-parity literal {gap,stop,data,start}.
    function automatic logic [11:0] exp_frame(input logic [10:0] fr, input logic par);
        if (P == 1) return {2'b11, par, fr[8:1], 1'b0};
        return {1'b0, fr};
    endfunction

    // Reference model: a word starts at the first edge after its push once the
    // previous frame (FLEN cycles) has ended; the line is low/high per frame_bit.
    logic [7:0] mq[$];
    int         cyc = 0;
    int         free_at = 0;
    int         cur_s = 0;
    logic [7:0] cur_w = 8'h00;
    bit         acc_flag = 1'b0;
    bit         acc;
    logic       e_pin_a, e_pin_c, e_busy, e_ready;

    always @(posedge clk) begin
        cyc++;
        acc = 1'b0;
        if (reset) begin
            mq.delete();
            free_at = cyc;
        end else begin
            acc = tx_valid && (mq.size() < DEPTH);
            if (mq.size() > 0 && cyc >= free_at) begin
                cur_w   = mq.pop_front();
                cur_s   = cyc;
                free_at = cyc + FLEN;
            end
            if (acc) mq.push_back(tx_data);
        end
        acc_flag = acc;
        #1;
        e_pin_a = (cyc < free_at) ? frame_bit(cur_w, (cyc - cur_s) / CLK, 1'b0) : 1'b1;
        e_pin_c = (cyc < free_at) ? frame_bit(cur_w, (cyc - cur_s) / CLK, 1'b1) : 1'b1;
        e_busy  = (mq.size() > 0) || (cyc < free_at);
        e_ready = !reset && (mq.size() < DEPTH);
        check("model_pin_a", tx_pin_a, e_pin_a);
        check("model_pin_c", tx_pin_c, e_pin_c);
        check("model_busy_a", busy_a, e_busy);
        check("model_busy_c", busy_c, e_busy);
        check("model_level_a", level_a, mq.size());
        check("model_level_c", level_c, mq.size());
        check("model_ready_a", tx_ready_a, e_ready);
        check("model_ready_c", tx_ready_c, e_ready);
    end

    // Independent serial receiver on dut_a: decodes words and records start cycles.
    logic [7:0] rx_words[$];
    int         rx_starts[$];
    bit         rx_busy = 1'b0;
    logic       rx_prev = 1'b1;
    int         rx_t0 = 0;
    int         rx_off;
    logic [7:0] rx_w = 8'h00;

    always @(posedge clk) begin
        #1;
        if (reset) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (rx_prev && !tx_pin_a) begin
                rx_busy = 1'b1;
                rx_t0   = cyc;
                rx_w    = 8'h00;
            end
        end else begin
            rx_off = cyc - rx_t0;
            if (rx_off % CLK == CLK / 2 && rx_off / CLK >= 1 && rx_off / CLK <= 8)
                rx_w[rx_off / CLK - 1] = tx_pin_a;
            if (rx_off == FLEN - 1) begin
                rx_busy = 1'b0;
                rx_words.push_back(rx_w);
                rx_starts.push_back(rx_t0);
            end
        end
        rx_prev = tx_pin_a;
    end

    typedef struct {
        logic [7:0]  w;
        logic [10:0] fr;
        logic        par;
    } vec_t;
    vec_t vecs[6];

    logic [7:0] bq[$];
    bit         seen_full;
    int         max_lvl;
    logic       pins_a[48];
    logic       pins_c[48];
    logic [11:0] got_a, got_c, ea, eb;
    logic       seqb[24];
    int         zeros;

    task automatic run_burst();
        int idx;
        int guard;
        idx = 0;
        guard = 0;
        seen_full = 1'b0;
        max_lvl = 0;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data  = bq[0];
        while (idx < bq.size() && guard < 500) begin
            @(posedge clk);
            #1;
            if (int'(level_a) > max_lvl) max_lvl = int'(level_a);
            if (level_a == 3'd4) begin
                seen_full = 1'b1;
                check("ready_low_when_full", tx_ready_a, 1'b0);
            end
            @(negedge clk);
            if (acc_flag) idx++;
            if (idx < bq.size()) tx_data = bq[idx];
            else                 tx_valid = 1'b0;
            guard++;
        end
        tx_valid = 1'b0;
        check("burst_accepted", idx, bq.size());
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (busy_a && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_idle", busy_a, 1'b0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_rx_order(input string tag);
        check({tag, "_rx_count"}, rx_words.size(), bq.size());
        for (int i = 0; i < rx_words.size() && i < bq.size(); i++) begin
            check({tag, "_rx_word"}, rx_words[i], bq[i]);
            if (i > 0) check({tag, "_period"}, rx_starts[i] - rx_starts[i-1], FLEN);
        end
    endtask

    initial begin
        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        b_valid  = 1'b0;
        b_data   = 8'h00;
        vecs[0] = '{8'h31, 11'h662, 1'b1};
        vecs[1] = '{8'h00, 11'h600, 1'b0};
        vecs[2] = '{8'hFF, 11'h7FE, 1'b0};
        vecs[3] = '{8'h55, 11'h6AA, 1'b0};
        vecs[4] = '{8'hA5, 11'h74A, 1'b0};
        vecs[5] = '{8'h07, 11'h60E, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_pin", tx_pin_a, 1'b1);
        check("rst_level", level_a, 3'd0);
        check("rst_busy", busy_a, 1'b0);
        check("rst_ready", tx_ready_a, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_rst", tx_ready_a, 1'b1);

        // Single-word frames from the table
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            tx_valid = 1'b1;
            tx_data  = vecs[t].w;
            @(posedge clk);
            @(negedge clk);
            tx_valid = 1'b0;
            for (int j = 0; j < FLEN; j++) begin
                @(posedge clk);
                #1;
                pins_a[j] = tx_pin_a;
                pins_c[j] = tx_pin_c;
                if (j == 0) check("start_latency", tx_pin_a, 1'b0);
            end
            check("busy_last_gap", busy_a, 1'b1);
            @(posedge clk);
            #1;
            check("busy_after_frame", busy_a, 1'b0);
            check("pin_after_frame", tx_pin_a, 1'b1);
            got_a = '0;
            got_c = '0;
            for (int i = 0; i < NB; i++) begin
                got_a[i] = pins_a[i*CLK + CLK/2];
                got_c[i] = pins_c[i*CLK + CLK/2];
            end
            check("table_frame_even", got_a, exp_frame(vecs[t].fr, vecs[t].par));
            check("table_frame_odd", got_c, exp_frame(vecs[t].fr, (P == 1) ? ~vecs[t].par : vecs[t].par));
        end

        // FIFO fill with valid held high: 6 words, back-to-back
        rx_words.delete();
        rx_starts.delete();
        bq = '{8'hA1, 8'h3C, 8'hF0, 8'h0F, 8'h96, 8'h69};
        run_burst();
        check("saw_full", seen_full, 1'b1);
        drain(6 * FLEN + 50);
        check_rx_order("fill");

        // Pointer wrap: 10 words through the depth-4 FIFO
        rx_words.delete();
        rx_starts.delete();
        bq.delete();
        for (int i = 0; i < 10; i++) bq.push_back(8'(i));
        run_burst();
        check("max_level_le_depth", max_lvl <= DEPTH, 1'b1);
        drain(10 * FLEN + 50);
        check_rx_order("wrap");

        // Reset mid-DATA of 0x55 with two words queued
        bq = '{8'h55, 8'h11, 8'h22};
        run_burst();
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("pre_reset_level", level_a, 3'd2);
        check("pre_reset_busy", busy_a, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_pin", tx_pin_a, 1'b1);
        check("midrst_level", level_a, 3'd0);
        check("midrst_busy", busy_a, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        zeros = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (!tx_pin_a) zeros++;
        end
        check("no_start_after_rst", zeros, 0);

        // Two stop bits, no gap, one clock per bit: 0xA5 then 0x5A back-to-back
        ea = exp_frame(11'h74A, 1'b0);
        eb = exp_frame(11'h6B4, 1'b0);
        for (int j = 0; j < NB; j++) begin
            seqb[j]      = ea[j];
            seqb[NB + j] = eb[j];
        end
        @(negedge clk);
        b_valid = 1'b1;
        b_data  = 8'hA5;
        @(posedge clk);
        @(negedge clk);
        b_data = 8'h5A;
        @(posedge clk);
        #1;
        check("b2b_pin_0", tx_pin_b, seqb[0]);
        check("b2b_level", level_b, 3'd1);
        check("b2b_ready", tx_ready_b, 1'b1);
        @(negedge clk);
        b_valid = 1'b0;
        for (int j = 1; j < 2 * NB; j++) begin
            @(posedge clk);
            #1;
            check("b2b_pin", tx_pin_b, seqb[j]);
        end
        @(posedge clk);
        #1;
        check("b2b_idle_pin", tx_pin_b, 1'b1);
        check("b2b_idle_busy", busy_b, 1'b0);

        // Randomized traffic, alternating light and heavy load, rare reset pulses
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            tx_valid = ($urandom_range(0, 7) < (((i / 500) % 2) ? 6 : 1));
            tx_data  = 8'($urandom);
            reset    = ($urandom_range(0, 599) == 0);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        reset    = 1'b0;
        drain(DEPTH * FLEN + 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed-string tx block.
- Accepts data words over a valid/ready handshake into an internal FIFO.
- Serialises each word as START, DATA (LSB first), optional PARITY, STOP, GAP, with a programmable bit period.
- Sits between any on-chip byte producer and the tx output pin; frames run back-to-back while the FIFO holds data.

Parameters:
CLKS_PER_BIT, 1, clk cycles per serial bit; must be >= 1
DATA_BITS, 8, data bits per frame; range 5..9
STOP_BITS, 1, stop bits per frame; 1 or 2
IDLE_BITS, 1, extra high bit-periods after stop (inter-frame gap); 0 allowed
FIFO_DEPTH, 4, FIFO entries; power of two, >= 2
PARITY_ODD, 0, 0 = even parity, 1 = odd parity; used only with UART_TX_PARITY_EN

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
tx_data  input  DATA_BITS  word to send
tx_valid  input  1  tx_data valid
tx_ready  output  1  FIFO can accept; high when FIFO not full
tx_pin  output  1  serial line, idle high, registered
busy  output  1  high when the FSM is not in IDLE or the FIFO is non-empty
fifo_level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy

Behaviour:
- Reset is synchronous, active-high, on clk.
- Reset values: tx_pin=1, FSM=IDLE, FIFO empty, fifo_level=0, busy=0, baud and bit counters 0.
- tx_ready=0 while reset is high; tx_ready=1 from the first cycle after reset deasserts.
- Push: a word is written on any edge with tx_valid & tx_ready.
  - tx_ready is derived from full only. A pop in the same cycle does not permit a push into a full FIFO.
- FIFO: circular buffer with read/write pointers that wrap modulo FIFO_DEPTH. A push and a pop in the same cycle leave fifo_level unchanged.
- FSM states: IDLE, START, DATA, PARITY, STOP, GAP.
- Every non-IDLE state holds tx_pin for CLKS_PER_BIT cycles per bit, using a baud counter 0..CLKS_PER_BIT-1.
- IDLE, tx_pin=1: if the FIFO is non-empty, pop the head into the shift register and enter START on the same edge.
- START, tx_pin=0: 1 bit-period -> DATA.
- DATA, tx_pin=shift[0]: shift right each bit-period; after DATA_BITS periods -> PARITY if enabled, else STOP.
- PARITY, tx_pin=parity bit: 1 bit-period -> STOP.
- STOP, tx_pin=1: STOP_BITS bit-periods -> GAP, or directly to the next step below if IDLE_BITS=0.
- GAP, tx_pin=1: IDLE_BITS bit-periods, then:
  - FIFO non-empty: pop and go directly to START, with no extra cycle;
  - FIFO empty: go to IDLE.
- Latency: with IDLE and the FIFO empty, a push on edge k -> pop on edge k+1 -> tx_pin=0 in the cycle after edge k+1.
- Frame length in cycles = (1 + DATA_BITS + P + STOP_BITS + IDLE_BITS) * CLKS_PER_BIT, where P=1 with parity, else 0.
- Back-to-back frames have exactly this period; no gap cycles are inserted beyond IDLE_BITS.
- Reset mid-frame: tx_pin returns to 1 on the reset edge, the FIFO is flushed and the frame is abandoned; no partial stop bit is generated.
- tx_data is sampled only at push; later changes do not affect queued words.

Optional Feature:
UART_TX_PARITY_EN
- Defined: PARITY state is present; parity bit = XOR of the data bits, inverted when PARITY_ODD=1.
- Undefined: no PARITY state and no parity logic; PARITY_ODD is ignored; P=0 in the frame length.

Test Plan:
1. Defaults with CLKS_PER_BIT=4. Push 0x31 once.
   - tx_pin falls one cycle after the push edge.
   - Pattern, 4 cycles each: 0, 1,0,0,0,1,1,0,0, 1 (stop), 1 (gap).
   - Frame is 44 cycles; busy drops after the gap.
2. UART_TX_PARITY_EN, PARITY_ODD=0, push 0x31 -> parity bit=1 (three ones), frame 48 cycles; PARITY_ODD=1 -> parity bit=0.
3. FIFO_DEPTH=4, CLKS_PER_BIT=4, tx_valid held high with 6 words queued.
   - tx_ready drops when fifo_level=4.
   - All 6 words go out back-to-back with a 44-cycle period and no extra idle cycles; order is preserved.
4. Pointer wrap: push/pop 10 words (0x00..0x09) through the depth-4 FIFO -> serial output matches in order; fifo_level never exceeds 4.
5. Reset asserted mid-DATA of 0x55 with 2 words queued -> tx_pin=1 on the reset edge; fifo_level=0, busy=0; no further start bits appear until a new push.
6. STOP_BITS=2, IDLE_BITS=0, CLKS_PER_BIT=1, push 0xA5,0x5A -> frames 11 cycles each; the second start bit immediately follows the second stop bit.
